ws2812_ctrl: RTL and testbench

//  Downstream consumer of the CPU I/O decoder's ws2812_* strobes. Holds a
//  per-LED RGB buffer behind I/O ports 30h-33h and drives one WS2812 serial

---
 rtl/ws2812_if.sv | 24 ++
 rtl/ws2812_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ws2812_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_if.sv
// CPU-side I/O strobe bus between the port 30h-33h decoder and the WS2812 controller.
interface ws2812_if;
    logic       ws2812_io_req;
    logic       ws2812_io_wr;
    logic [1:0] ws2812_io_addr;
    logic [7:0] ws2812_data_in;
    logic [7:0] ws2812_data_out;

    modport master (
        output ws2812_io_req,
        output ws2812_io_wr,
        output ws2812_io_addr,
        output ws2812_data_in,
        input  ws2812_data_out
    );

    modport slave (
        input  ws2812_io_req,
        input  ws2812_io_wr,
        input  ws2812_io_addr,
        input  ws2812_data_in,
        output ws2812_data_out
    );
endinterface

// File: rtl/ws2812_ctrl.sv
// WS2812 strip controller: per-LED RGB buffer behind ports 30h-33h and a
// serial transmitter that refreshes the strip whenever the buffer or length changes.
module ws2812_ctrl #(
    parameter int MAX_LEDS = 256,
    parameter int T0H_CYC  = 11,
    parameter int T1H_CYC  = 22,
    parameter int BIT_CYC  = 34,
    parameter int RST_CYC  = 2160
) (
    input  logic     clk,
    input  logic     reset_n,
    ws2812_if.slave  bus,
    output logic     ws2812_dout,
    output logic     ws2812_busy
);

    localparam int CW = 12;
    localparam int AW = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    led_idx_q, led_idx_d;
    logic [1:0]    byte_sel_q, byte_sel_d;
    logic [7:0]    led_count_q, led_count_d;
    logic          dirty_q, dirty_d;
    logic [8:0]    tx_led_q, tx_led_d;
    logic [4:0]    bit_n_q, bit_n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_out_q, data_out_d;
    logic [23:0]   rd_word_q;

    logic [7:0]    mem_r [MAX_LEDS];
    logic [7:0]    mem_g [MAX_LEDS];
    logic [7:0]    mem_b [MAX_LEDS];

    logic          idx_ok;
    logic          buf_we;
    logic          set_dirty;
    logic [7:0]    buf_rd;
    logic [8:0]    tx_next;
    logic [8:0]    tx_end;
    logic [CW-1:0] hi_last;
    logic [CW-1:0] lo_last;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] tx_addr;

    assign cpu_addr = led_idx_q[AW-1:0];
    assign tx_addr  = tx_led_q[AW-1:0];
    assign idx_ok   = ({1'b0, led_idx_q} < 9'(MAX_LEDS));
    assign buf_we   = bus.ws2812_io_req && bus.ws2812_io_wr &&
                      (bus.ws2812_io_addr == 2'd1) && idx_ok;

    // Port A: CPU byte writes. Port B: registered tx read, returns the pre-write word on collision.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            case (byte_sel_q)
                2'd0:    mem_r[cpu_addr] <= bus.ws2812_data_in;
                2'd1:    mem_g[cpu_addr] <= bus.ws2812_data_in;
                default: mem_b[cpu_addr] <= bus.ws2812_data_in;
            endcase
        end
        rd_word_q <= {mem_g[tx_addr], mem_r[tx_addr], mem_b[tx_addr]};
    end

    always_comb begin
        case (byte_sel_q)
            2'd0:    buf_rd = mem_r[cpu_addr];
            2'd1:    buf_rd = mem_g[cpu_addr];
            default: buf_rd = mem_b[cpu_addr];
        endcase
    end

    assign tx_next = tx_led_q + 9'd1;
    assign tx_end  = ({1'b0, led_count_q} < 9'(MAX_LEDS)) ? {1'b0, led_count_q} : 9'(MAX_LEDS);
    assign hi_last = shift_q[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
    assign lo_last = shift_q[23] ? CW'(BIT_CYC - T1H_CYC - 1) : CW'(BIT_CYC - T0H_CYC - 1);

    always_comb begin
        state_d     = state_q;
        led_idx_d   = led_idx_q;
        byte_sel_d  = byte_sel_q;
        led_count_d = led_count_q;
        dirty_d     = dirty_q;
        tx_led_d    = tx_led_q;
        bit_n_d     = bit_n_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        set_dirty   = 1'b0;

        if (bus.ws2812_io_req) begin
            case (bus.ws2812_io_addr)
                2'd0: begin
                    if (bus.ws2812_io_wr) begin
                        led_idx_d  = bus.ws2812_data_in;
                        byte_sel_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (byte_sel_q == 2'd2) begin
                        byte_sel_d = 2'd0;
                        led_idx_d  = led_idx_q + 8'd1;
                        set_dirty  = bus.ws2812_io_wr;
                    end else begin
                        byte_sel_d = byte_sel_q + 2'd1;
                    end
                end
                2'd2: begin
                    if (bus.ws2812_io_wr) begin
                        led_count_d = bus.ws2812_data_in;
                        set_dirty   = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    dirty_d = 1'b0;
                    if (led_count_q != 8'd0) begin
                        tx_led_d = '0;
                        cnt_d    = '0;
                        state_d  = S_LOAD;
                    end
                end
            end
            // First LOAD cycle presents tx_led to the RAM, second captures the word.
            S_LOAD: begin
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else begin
                    shift_d = rd_word_q;
                    bit_n_d = 5'd23;
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == hi_last) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == lo_last) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_n_q == 5'd0) begin
                        tx_led_d = tx_next;
                        state_d  = (tx_next < tx_end) ? S_LOAD : S_LATCH;
                    end else begin
                        bit_n_d = bit_n_q - 5'd1;
                        state_d = S_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A CPU dirty event on the same clock the FSM consumes dirty must survive.
        if (set_dirty) begin
            dirty_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        dout_d = (state_d == S_HIGH);

        case (bus.ws2812_io_addr)
            2'd0:    data_out_d = led_idx_q;
            2'd1:    data_out_d = idx_ok ? buf_rd : 8'h00;
            2'd2:    data_out_d = led_count_q;
            default: data_out_d = {busy_q, dirty_q, 6'b0};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            led_idx_q   <= '0;
            byte_sel_q  <= '0;
            led_count_q <= '0;
            dirty_q     <= 1'b0;
            tx_led_q    <= '0;
            bit_n_q     <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            led_idx_q   <= led_idx_d;
            byte_sel_q  <= byte_sel_d;
            led_count_q <= led_count_d;
            dirty_q     <= dirty_d;
            tx_led_q    <= tx_led_d;
            bit_n_q     <= bit_n_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            data_out_q  <= data_out_d;
        end
    end

    assign ws2812_dout         = dout_q;
    assign ws2812_busy         = busy_q;
    assign bus.ws2812_data_out = data_out_q;

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Directed bench for ws2812_ctrl: port access, frame serialisation, re-arm and reset.
module tb_ws2812_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic dout;
    logic busy;
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_cnt = 0;
    int   dout_cnt = 0;
    bit   stall = 1'b0;

    ws2812_if bus();

    ws2812_ctrl #(
        .MAX_LEDS(256),
        .T0H_CYC (11),
        .T1H_CYC (22),
        .BIT_CYC (34),
        .RST_CYC (2160)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .ws2812_dout(dout),
        .ws2812_busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (dout === 1'b1) dout_cnt = dout_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ws2812_io_req  = 1'b1;
        bus.ws2812_io_wr   = 1'b1;
        bus.ws2812_io_addr = a;
        bus.ws2812_data_in = d;
        @(negedge clk);
        bus.ws2812_io_req  = 1'b0;
        bus.ws2812_io_wr   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.ws2812_io_addr = a;
        @(negedge clk);
        @(negedge clk);
        check(tag, {24'h0, bus.ws2812_data_out}, {24'h0, exp});
    endtask

    task automatic rd_strobe();
        @(negedge clk);
        bus.ws2812_io_req = 1'b1;
        bus.ws2812_io_wr  = 1'b0;
        @(negedge clk);
        bus.ws2812_io_req = 1'b0;
    endtask

    task automatic rx_bit(output int hi, output int lo);
        int t = 0;
        hi = 0;
        lo = 0;
        while (dout !== 1'b1 && t < 3000 && !stall) begin
            @(negedge clk);
            t++;
        end
        if (dout !== 1'b1) begin
            stall = 1'b1;
            check("rx_bit_start", {31'h0, dout}, 32'h1);
            return;
        end
        while (dout === 1'b1 && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        while (dout === 1'b0 && busy === 1'b1 && lo < 3000) begin
            @(negedge clk);
            lo++;
        end
    endtask

    task automatic rx_led(output logic [23:0] w, output int last_lo);
        int hi;
        int lo;
        w = '0;
        last_lo = 0;
        for (int i = 0; i < 24; i++) begin
            rx_bit(hi, lo);
            check("bit_high_width", {31'h0, (hi == 11 || hi == 22)}, 32'h1);
            w = {w[22:0], (hi == 22)};
            if (i < 23) check("bit_period", hi + lo, 34);
            last_lo = lo;
        end
    endtask

    initial begin
        logic [23:0] w;
        int lo;
        int hi;
        int b0;
        int d0;

        bus.ws2812_io_req  = 1'b0;
        bus.ws2812_io_wr   = 1'b0;
        bus.ws2812_io_addr = 2'd0;
        bus.ws2812_data_in = 8'h00;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_dout", {31'h0, dout}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rd(2'd0, 8'h00, "rst_idx");
        rd(2'd2, 8'h00, "rst_count");
        rd(2'd3, 8'h00, "rst_status");

        // single LED frame: R=FF G=00 B=80 goes out as 00FF80
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        wr(2'd1, 8'h00);
        wr(2'd1, 8'h80);
        rd(2'd0, 8'h01, "t1_idx_after_led");
        wr(2'd2, 8'h01);
        rx_led(w, lo);
        check("t1_frame_word", {8'h0, w}, 32'h0000FF80);
        check("t1_last_low_plus_latch", lo, 2183);
        check("t1_busy_fall", {31'h0, busy}, 32'h0);
        rd(2'd3, 8'h00, "t1_status_idle");

        // zero-length strip: dirty consumed, no frame
        b0 = busy_cnt;
        d0 = dout_cnt;
        wr(2'd2, 8'h00);
        repeat (200) @(negedge clk);
        check("t5_no_busy", busy_cnt - b0, 0);
        check("t5_no_dout", dout_cnt - d0, 0);
        rd(2'd3, 8'h00, "t5_status");
        rd(2'd2, 8'h00, "t5_count");

        // reads of buf[5] in R,G,B order advance the pointer
        wr(2'd0, 8'h05);
        wr(2'd1, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd1, 8'h33);
        wr(2'd0, 8'h05);
        b0 = busy_cnt;
        rd(2'd1, 8'h11, "t2_read_r");
        rd_strobe();
        rd(2'd1, 8'h22, "t2_read_g");
        rd_strobe();
        rd(2'd1, 8'h33, "t2_read_b");
        rd_strobe();
        rd(2'd0, 8'h06, "t2_idx_after_reads");
        check("t2_no_frame", busy_cnt - b0, 0);

        // pointer wrap at LED 255
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hA1);
        wr(2'd1, 8'hB2);
        wr(2'd1, 8'hC3);
        rd(2'd0, 8'h00, "t3_idx_wrap");
        wr(2'd0, 8'hFF);
        rd(2'd1, 8'hA1, "t3_buf255_r");
        rd_strobe();
        rd(2'd1, 8'hB2, "t3_buf255_g");
        rd_strobe();
        rd(2'd1, 8'hC3, "t3_buf255_b");
        rd_strobe();
        rd(2'd0, 8'h00, "t3_idx_wrap_read");

        // three LEDs, LED0 rewritten mid-frame re-arms exactly one more frame
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h12); wr(2'd1, 8'h34); wr(2'd1, 8'h56);
        wr(2'd1, 8'hAA); wr(2'd1, 8'h55); wr(2'd1, 8'h0F);
        wr(2'd1, 8'h01); wr(2'd1, 8'h80); wr(2'd1, 8'hFE);
        wr(2'd2, 8'h03);
        fork
            begin
                rx_led(w, lo);
                check("t4_f1_led0", {8'h0, w}, 32'h00341256);
                rx_led(w, lo);
                check("t4_f1_led1", {8'h0, w}, 32'h0055AA0F);
                rx_led(w, lo);
                check("t4_f1_led2", {8'h0, w}, 32'h008001FE);
                check("t4_f1_latch", lo, 2183);
            end
            begin
                repeat (1000) @(negedge clk);
                wr(2'd0, 8'h00);
                wr(2'd1, 8'hC3);
                wr(2'd1, 8'h3C);
                wr(2'd1, 8'h99);
                rd(2'd3, 8'hC0, "t4_status_busy_dirty");
            end
        join
        rx_led(w, lo);
        check("t4_f2_led0", {8'h0, w}, 32'h003CC399);
        rx_led(w, lo);
        check("t4_f2_led1", {8'h0, w}, 32'h0055AA0F);
        rx_led(w, lo);
        check("t4_f2_led2", {8'h0, w}, 32'h008001FE);
        check("t4_f2_latch", lo, 2183);
        b0 = busy_cnt;
        repeat (3000) @(negedge clk);
        check("t4_only_two_frames", busy_cnt - b0, 0);

        // reset during bit 10 of LED 1
        wr(2'd2, 8'h02);
        rx_led(w, lo);
        check("t6_led0", {8'h0, w}, 32'h003CC399);
        for (int i = 0; i < 10; i++) rx_bit(hi, lo);
        check("t6_at_bit10_high", {31'h0, dout}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_dout", {31'h0, dout}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_data_out", {24'h0, bus.ws2812_data_out}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        b0 = busy_cnt;
        rd(2'd0, 8'h00, "t6_idx");
        rd(2'd2, 8'h00, "t6_count");
        rd(2'd3, 8'h00, "t6_status");
        repeat (200) @(negedge clk);
        check("t6_no_frame", busy_cnt - b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
